// File: rtl/tx9_link_pkg.sv
// Shared types, widths and symbol helpers for the 9-lane 40:10 LVDS
// transmit link sequencer.
package tx9_link_pkg;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_TRAIN     = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  localparam int NLANES = 9;
  localparam int LANE_W = 40;
  localparam int SYM_W  = 10;
  localparam int NPHASE = 4;
  localparam int WORD_W = NLANES * LANE_W;

  localparam logic [SYM_W-1:0] TRAIN_PAT_DEF = 10'h3E0;
  localparam logic [SYM_W-1:0] IDLE_PAT_DEF  = 10'h155;

  function automatic logic [WORD_W-1:0] rep_sym(
    input logic [SYM_W-1:0] s
  );
    return {(WORD_W/SYM_W){s}};
  endfunction

endpackage

// File: rtl/tx9_lock_mon.sv
// PLL lock synchronizer and stability qualifier for the tx9 link.
// Qualified once the synced lock has been high LOCK_STABLE cycles in a row.
module tx9_lock_mon #(
  parameter int LOCK_STABLE = 256
) (
  input  logic I_clk,
  input  logic I_rst_n,
  input  logic I_lock,
  output logic O_synced,
  output logic O_qualified
);

  localparam int CW = $clog2(LOCK_STABLE + 1);
  localparam logic [CW-1:0] CMAX = CW'(LOCK_STABLE);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[0], I_lock};
    cnt_d  = '0;
    // cnt_d counts the current synced-high cycle as well
    if (sync_q[1]) begin
      cnt_d = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

  assign O_synced    = sync_q[1];
  assign O_qualified = (cnt_d == CMAX);

endmodule

// File: rtl/tx9_link_seq.sv
// Link sequencer: PLL reset, lock wait, training and 360-bit word
// streaming to the 9-lane 40:10 mux/serializer wrapper.
module tx9_link_seq
  import tx9_link_pkg::*;
#(
  parameter int               PLL_RST_CYC  = 16,
  parameter int               LOCK_STABLE  = 256,
  parameter int               LOCK_TIMEOUT = 65535,
  parameter int               TRAIN_WORDS  = 64,
  parameter logic [SYM_W-1:0] TRAIN_PAT    = TRAIN_PAT_DEF,
  parameter logic [SYM_W-1:0] IDLE_PAT     = IDLE_PAT_DEF
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_tx_locked,
  input  logic              I_valid,
  input  logic [WORD_W-1:0] I_data,
  input  logic              I_train_req,
  output logic              O_ready,
  output logic [WORD_W-1:0] O_word,
  output logic [1:0]        O_sel,
  output logic              O_pll_areset,
  output logic              O_link_up,
  output logic [15:0]       O_underrun_cnt,
  output logic [1:0]        O_state
);

  localparam logic [WORD_W-1:0] TRAIN_W = rep_sym(TRAIN_PAT);
  localparam logic [WORD_W-1:0] IDLE_W  = rep_sym(IDLE_PAT);
  // counters are 16 bits wide; parameters must stay within that range
  localparam logic [15:0] RST_LAST = 16'(PLL_RST_CYC - 1);
  localparam logic [15:0] TMO_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] TW_LAST  = 16'(TRAIN_WORDS - 1);

  state_e            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              link_up_q, link_up_d;
  logic [15:0]       und_q, und_d;
  logic [15:0]       rst_cnt_q, rst_cnt_d;
  logic [15:0]       tmo_q, tmo_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic              pend_q, pend_d;

  logic lock_sync;
  logic lock_qual;
  logic bnd;
  logic lost;
  logic hs;

  tx9_lock_mon #(
    .LOCK_STABLE (LOCK_STABLE)
  ) u_lock_mon (
    .I_clk       (I_clk),
    .I_rst_n     (I_rst_n),
    .I_lock      (I_tx_locked),
    .O_synced    (lock_sync),
    .O_qualified (lock_qual)
  );

  assign bnd     = (sel_q == 2'd3);
  assign O_ready = (state_q == ST_RUN) && bnd && !pend_q;
  assign hs      = I_valid && O_ready;
  assign lost    = ((state_q == ST_TRAIN) || (state_q == ST_RUN))
                   && !lock_sync;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    word_d    = word_q;
    link_up_d = link_up_q;
    und_d     = und_q;
    rst_cnt_d = rst_cnt_q;
    tmo_d     = tmo_q;
    wcnt_d    = wcnt_q;
    pend_d    = pend_q;
    if (lost) begin
      state_d   = ST_PLL_RST;
      sel_d     = 2'd0;
      word_d    = IDLE_W;
      link_up_d = 1'b0;
      rst_cnt_d = '0;
      pend_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_PLL_RST: begin
          sel_d     = 2'd0;
          word_d    = IDLE_W;
          link_up_d = 1'b0;
          pend_d    = 1'b0;
          rst_cnt_d = rst_cnt_q + 16'd1;
          if (rst_cnt_q == RST_LAST) begin
            state_d   = ST_WAIT_LOCK;
            rst_cnt_d = '0;
            tmo_d     = '0;
          end
        end
        ST_WAIT_LOCK: begin
          tmo_d = tmo_q + 16'd1;
          if (lock_qual) begin
            state_d = ST_TRAIN;
            sel_d   = 2'd0;
            wcnt_d  = '0;
            word_d  = TRAIN_W;
          end else if (tmo_q == TMO_LAST) begin
            state_d   = ST_PLL_RST;
            rst_cnt_d = '0;
          end
        end
        ST_TRAIN: begin
          sel_d = sel_q + 2'd1;
          if (bnd) begin
            wcnt_d = wcnt_q + 16'd1;
            if (wcnt_q == TW_LAST) begin
              state_d   = ST_RUN;
              link_up_d = 1'b1;
              word_d    = IDLE_W;
            end
          end
        end
        ST_RUN: begin
          sel_d = sel_q + 2'd1;
          if (I_train_req) pend_d = 1'b1;
          if (bnd) begin
            // a pending retrain leaves RUN at this boundary
            if (pend_q) begin
              state_d   = ST_TRAIN;
              wcnt_d    = '0;
              word_d    = TRAIN_W;
              pend_d    = 1'b0;
              link_up_d = 1'b0;
            end else if (hs) begin
              word_d = I_data;
            end else begin
              word_d = IDLE_W;
              if (und_q != 16'hFFFF) und_d = und_q + 16'd1;
            end
          end
        end
        default: state_d = ST_PLL_RST;
      endcase
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= ST_PLL_RST;
      sel_q     <= 2'd0;
      word_q    <= IDLE_W;
      link_up_q <= 1'b0;
      und_q     <= '0;
      rst_cnt_q <= '0;
      tmo_q     <= '0;
      wcnt_q    <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      word_q    <= word_d;
      link_up_q <= link_up_d;
      und_q     <= und_d;
      rst_cnt_q <= rst_cnt_d;
      tmo_q     <= tmo_d;
      wcnt_q    <= wcnt_d;
      pend_q    <= pend_d;
    end
  end

  assign O_word         = word_q;
  assign O_sel          = sel_q;
  assign O_pll_areset   = (state_q == ST_PLL_RST);
  assign O_link_up      = link_up_q;
  assign O_underrun_cnt = und_q;
  assign O_state        = state_q;

endmodule

// File: tb/tb_tx9_link_seq.sv
// Directed bench for tx9_link_seq: bring-up, streaming, underrun,
// retrain, lock loss, lock timeout and asynchronous reset.
module tb_tx9_link_seq;

  logic         I_clk = 1'b0;
  logic         I_rst_n = 1'b0;
  logic         I_tx_locked = 1'b0;
  logic         I_valid = 1'b0;
  logic [359:0] I_data = '0;
  logic         I_train_req = 1'b0;
  logic         O_ready;
  logic [359:0] O_word;
  logic [1:0]   O_sel;
  logic         O_pll_areset;
  logic         O_link_up;
  logic [15:0]  O_underrun_cnt;
  logic [1:0]   O_state;

  tx9_link_seq dut (
    .I_clk          (I_clk),
    .I_rst_n        (I_rst_n),
    .I_tx_locked    (I_tx_locked),
    .I_valid        (I_valid),
    .I_data         (I_data),
    .I_train_req    (I_train_req),
    .O_ready        (O_ready),
    .O_word         (O_word),
    .O_sel          (O_sel),
    .O_pll_areset   (O_pll_areset),
    .O_link_up      (O_link_up),
    .O_underrun_cnt (O_underrun_cnt),
    .O_state        (O_state)
  );

  always #5 I_clk = ~I_clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [359:0] idle_w;
  logic [359:0] train_w;
  logic [1:0]   ph;
  logic [359:0] cur;
  int           errs;
  int           n_acc;
  int           und_exp;

  task automatic chk(input string tag, input logic [359:0] got,
                     input logic [359:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [359:0] mkw(input int w);
    logic [359:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[40*k +: 40] = {16'(w), 8'(k), 16'hC0DE};
    return r;
  endfunction

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  // one RUN cycle against the bench's phase/word model
  task automatic run_step(input logic v, input logic [359:0] d);
    logic er;
    I_valid = v;
    I_data  = d;
    er = (ph == 2'd3);
    if (O_ready !== er) errs++;
    tick();
    if (ph == 2'd3) begin
      if (er && v) begin
        cur = d;
        n_acc++;
      end else begin
        cur = idle_w;
        und_exp++;
      end
    end
    ph = ph + 2'd1;
    if (O_word !== cur || O_sel !== ph || O_state !== 2'd3) errs++;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_state"}, 360'(O_state), 360'(0));
    chk({pfx, "_areset"}, 360'(O_pll_areset), 360'(1));
    chk({pfx, "_sel"}, 360'(O_sel), 360'(0));
    chk({pfx, "_word"}, O_word, idle_w);
    chk({pfx, "_ready"}, 360'(O_ready), 360'(0));
    chk({pfx, "_linkup"}, 360'(O_link_up), 360'(0));
    chk({pfx, "_und"}, 360'(O_underrun_cnt), 360'(0));
  endtask

  initial begin
    int hi;
    int last_hi;
    int n;
    int m;
    int serr;
    int ap;
    int t;
    idle_w  = {36{10'h155}};
    train_w = {36{10'h3E0}};
    errs = 0;
    n_acc = 0;
    und_exp = 0;

    repeat (3) tick();
    chk_reset_vals("rst");

    // bring-up
    I_rst_n = 1'b1;
    hi = 0;
    last_hi = -1;
    for (int c = 0; c < 40; c++) begin
      if (O_pll_areset) begin
        hi++;
        last_hi = c;
      end
      tick();
    end
    chk("areset_cycles", 360'(hi), 360'(16));
    chk("areset_last", 360'(last_hi), 360'(15));
    chk("wait_lock_state", 360'(O_state), 360'(1));

    I_tx_locked = 1'b1;
    n = 0;
    while (O_state !== 2'd2 && n < 1000) begin
      tick();
      n++;
    end
    chk("lock_to_train", 360'(n), 360'(258));
    chk("train_sel0", 360'(O_sel), 360'(0));
    chk("train_word", O_word, train_w);

    m = 0;
    serr = 0;
    while (O_state === 2'd2 && m < 1000) begin
      if (O_sel !== 2'(m)) serr++;
      if (O_word !== train_w) serr++;
      tick();
      m++;
    end
    chk("train_len", 360'(m), 360'(256));
    chk("train_seq", 360'(serr), 360'(0));
    chk("run_state", 360'(O_state), 360'(3));
    chk("run_linkup", 360'(O_link_up), 360'(1));
    chk("run_sel0", 360'(O_sel), 360'(0));

    // streaming
    ph = 2'd0;
    cur = idle_w;
    errs = 0;
    for (int w = 1; w <= 6; w++) repeat (4) run_step(1'b1, mkw(w));
    chk("stream_model", 360'(errs), 360'(0));
    chk("stream_acc", 360'(n_acc), 360'(6));
    chk("stream_last", O_word, mkw(6));
    chk("stream_und", 360'(O_underrun_cnt), 360'(0));

    // underrun
    errs = 0;
    repeat (12) run_step(1'b0, '1);
    chk("und_model", 360'(errs), 360'(0));
    chk("und_cnt", 360'(O_underrun_cnt), 360'(3));
    chk("und_word", O_word, idle_w);

    // retrain requested on a handshake boundary
    errs = 0;
    repeat (3) run_step(1'b1, mkw(7));
    I_train_req = 1'b1;
    run_step(1'b1, mkw(7));
    I_train_req = 1'b0;
    repeat (3) run_step(1'b1, mkw(8));
    chk("retrain_model", 360'(errs), 360'(0));
    chk("retrain_acc", 360'(n_acc), 360'(7));
    chk("retrain_held", O_word, mkw(7));
    chk("retrain_rdy", 360'(O_ready), 360'(0));
    tick();
    I_valid = 1'b0;
    chk("retrain_state", 360'(O_state), 360'(2));
    chk("retrain_word", O_word, train_w);
    chk("retrain_sel", 360'(O_sel), 360'(0));
    m = 0;
    ap = 0;
    while (O_state === 2'd2 && m < 1000) begin
      if (O_pll_areset) ap++;
      tick();
      m++;
    end
    chk("retrain_len", 360'(m), 360'(256));
    chk("retrain_noareset", 360'(ap), 360'(0));
    chk("retrain_run", 360'(O_state), 360'(3));

    // lock loss mid-word
    ph = 2'd0;
    cur = idle_w;
    errs = 0;
    repeat (4) run_step(1'b1, mkw(9));
    run_step(1'b1, mkw(10));
    chk("loss_model", 360'(errs), 360'(0));
    chk("loss_preword", O_word, mkw(9));
    I_tx_locked = 1'b0;
    I_valid = 1'b0;
    n = 0;
    while (O_state !== 2'd0 && n < 10) begin
      tick();
      n++;
    end
    chk("loss_lat", 360'(n), 360'(3));
    chk("loss_linkup", 360'(O_link_up), 360'(0));
    chk("loss_sel", 360'(O_sel), 360'(0));
    chk("loss_ready", 360'(O_ready), 360'(0));
    chk("loss_areset", 360'(O_pll_areset), 360'(1));
    chk("loss_word", O_word, idle_w);

    // lock timeout
    n = 0;
    while (O_state !== 2'd1 && n < 100) begin
      tick();
      n++;
    end
    chk("tmo_wait", 360'(O_state), 360'(1));
    t = 0;
    while (O_state === 2'd1 && t < 70000) begin
      t++;
      tick();
    end
    chk("tmo_len", 360'(t), 360'(65535));
    chk("tmo_retry", 360'(O_state), 360'(0));

    // asynchronous reset in TRAIN
    I_tx_locked = 1'b1;
    n = 0;
    while (O_state !== 2'd2 && n < 2000) begin
      tick();
      n++;
    end
    chk("ar_train", 360'(O_state), 360'(2));
    repeat (10) tick();
    chk("ar_und_pre", 360'(O_underrun_cnt), 360'(3));
    #2 I_rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tx9_link_seq.md
# tx9_link_seq

Sequencer for the 9-lane 40:10 LVDS transmit path. It owns PLL reset and lock qualification, and drives the 2-bit lane-mux phase select. It also runs a training pattern after lock, then feeds 360-bit user words, 9 lanes × 40 bits, through a one-word valid/ready handshake. It sits between the user transmit logic and the 9-lane mux/serializer wrapper, sourcing that wrapper's `I_pll_areset`, `I_sel` and `i0_p..i8_p`, and consuming its `O_tx_locked`.

## Interface
- `PLL_RST_CYC`, 16: cycles `O_pll_areset` is held high per PLL reset.
- `LOCK_STABLE`, 256: consecutive synced-lock cycles required before training.
- `LOCK_TIMEOUT`, 65535: WAIT_LOCK cycles before retrying PLL reset.
- `TRAIN_WORDS`, 64: training words (4 phases each) per training run.
- `TRAIN_PAT`, 10'h3E0: 10-bit training symbol, replicated 4× per lane.
- `IDLE_PAT`, 10'h155: 10-bit idle symbol, replicated 4× per lane.
- `I_clk` in 1: core clock; one clock domain only.
- `I_rst_n` in 1: reset, asynchronous assert, active-low.
- `I_tx_locked` in 1: serializer PLL lock, asynchronous to `I_clk`.
- `I_valid` in 1: user word valid.
- `I_data` in 360: user word; lane k = `I_data[40k+39:40k]`.
- `I_train_req` in 1: single-cycle pulse requesting retrain without a PLL reset.
- `O_ready` in/out: out 1: word accepted on `I_valid && O_ready`.
- `O_word` out 360: registered word to the lane muxes; lane k = bits `[40k+39:40k]`.
- `O_sel` out 2: mux phase select.
- `O_pll_areset` out 1: PLL reset.
- `O_link_up` out 1: high only in RUN.
- `O_underrun_cnt` out 16: saturating count of idle words inserted in RUN.
- `O_state` out 2: 0=PLL_RST, 1=WAIT_LOCK, 2=TRAIN, 3=RUN.

## Operation
- Lock sync: 2-flop synchronizer on `I_tx_locked`, followed by a stability counter. The counter clears whenever the synced lock is low, and "qualified" = count ≥ `LOCK_STABLE`.
- **PLL_RST:** `O_pll_areset`=1 for `PLL_RST_CYC` cycles; then go to WAIT_LOCK. `O_sel` is held 0 and `O_word` is held at idle.
- **WAIT_LOCK:** `O_pll_areset`=0 and a timeout counter runs.
  - Qualified: go to TRAIN with `O_sel`=0.
  - Timeout reaches `LOCK_TIMEOUT`: go to PLL_RST.
- **TRAIN:** `O_word` = all lanes {4{`TRAIN_PAT`}}, and `O_sel` increments every cycle, wrapping 3→0.
  - A word counter increments at each boundary (`O_sel`==3).
  - After `TRAIN_WORDS` boundaries, go to RUN with `O_sel`=0.
- **RUN:** `O_sel` cycles 0..3.
  - `O_ready` = (state==RUN) && (`O_sel`==3) && !train_pending. It is combinational from registers only and never depends on `I_valid`.
  - At a boundary with a handshake: `O_word` ← `I_data`.
  - At a boundary without one: `O_word` ← idle, and `O_underrun_cnt` increments, saturating at 16'hFFFF.
- `I_train_req` in RUN sets train_pending. At the next boundary the state goes to TRAIN: word counter cleared, `O_word` ← training, train_pending cleared.
  - A request arriving on the boundary cycle itself completes any handshake already offered that cycle. TRAIN then starts at the following boundary.
  - `I_train_req` outside RUN is ignored.
- Loss of synced lock while in TRAIN or RUN: next cycle go to PLL_RST. Any loaded word is dropped, `O_word` ← idle, `O_sel` ← 0, `O_link_up` ← 0.
- `O_underrun_cnt` clears only on reset.

## Timing
- **Reset values:** state PLL_RST, `O_pll_areset`=1, `O_sel`=0, `O_word`=idle, `O_ready`=0, `O_link_up`=0, `O_underrun_cnt`=0. Reset also clears all counters and train_pending.
- **Lock-to-TRAIN latency:** 2 (sync) + `LOCK_STABLE` cycles after `I_tx_locked` rises and stays high.
- **Loss-of-lock latency:** 2 (sync) + 1 cycle to PLL_RST.
- **Handshake to output:** accepted word appears on `O_word` on the edge after the handshake, with `O_sel`=0. It is then held for exactly 4 cycles.
- **Throughput:** one word every 4 cycles; `O_ready` is high 1 cycle in 4.
- **TRAIN duration:** `TRAIN_WORDS`×4 cycles.
- **Registered outputs:** `O_link_up` and `O_state` are registered. `O_link_up` rises the same edge state enters RUN.

## Structure
- Package `tx9_link_pkg` holds:
  - state encoding;
  - lane count (9), lane width (40), symbol width (10), phase count (4);
  - default `TRAIN_PAT` and `IDLE_PAT`;
  - a function replicating a 10-bit symbol to a 360-bit word.
- Sub-module `tx9_lock_mon`: the synchronizer plus stability counter, outputting synced and qualified lock. Everything else stays in the top.

## Test plan
- **Bring-up:** reset, then raise `I_tx_locked` at cycle 40. Required: `O_pll_areset` high for cycles 0–15; TRAIN entered 258 cycles after lock; 256 training cycles; then `O_link_up`=1.
- **Streaming:** `I_valid` held high with an incrementing word. Required: one accept per 4 cycles, each word on `O_word` for `O_sel` 0..3 in order, `O_underrun_cnt` stays 0.
- **Underrun:** `I_valid` low for 3 boundaries in RUN. Required: 3 idle words (lanes = {4{10'h155}}) and `O_underrun_cnt`=3.
- **Retrain:** `I_train_req` pulsed on a boundary cycle while a handshake completes. Required: that word is sent, then 64 training words, then RUN resumes with no `O_pll_areset` pulse.
- **Lock loss:** drop `I_tx_locked` mid-word in RUN. Required: within 3 cycles state=PLL_RST, `O_link_up`=0, `O_sel`=0, `O_ready`=0, `O_pll_areset`=1.
- **Timeout and async reset:** hold `I_tx_locked` low. Required: a PLL_RST retry after 65535 WAIT_LOCK cycles. Asserting `I_rst_n` mid-TRAIN returns all outputs to their reset values immediately.
